// File: rtl/decode_pipe_stage_pkg.sv
// Shared opcodes, funct codes, instruction field positions and the
// fixed-width part of the DECODE -> EXECUTE bundle.
package decode_pipe_stage_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_JUMP  = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LDB   = 6'h20;
    localparam logic [5:0] OP_LDW   = 6'h23;
    localparam logic [5:0] OP_STB   = 6'h28;
    localparam logic [5:0] OP_STW   = 6'h2B;

    localparam logic [5:0] FN_MUL = 6'h18;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;

    localparam int OPC_HI = 31;
    localparam int OPC_LO = 26;
    localparam int RS_HI  = 25;
    localparam int RS_LO  = 21;
    localparam int RT_HI  = 20;
    localparam int RT_LO  = 16;
    localparam int RD_HI  = 15;
    localparam int RD_LO  = 11;
    localparam int FN_HI  = 5;
    localparam int FN_LO  = 0;
    localparam int IMM_HI = 20;
    localparam int JT_HI  = 25;

    typedef struct packed {
        logic regwrite;
        logic memtoreg;
        logic branch;
        logic memwrite;
        logic memread;
        logic byteword;
        logic alusrc;
    } ctrl_t;

    typedef struct packed {
        logic [5:0] op;
        logic [5:0] fn;
        ctrl_t      ctrl;
        logic       is_mult;
    } id_ex_ctl_t;

    function automatic logic is_mul_op(
        input logic [5:0] op,
        input logic [5:0] fn
    );
        return (op == OP_RTYPE) && (fn == FN_MUL);
    endfunction

endpackage

// File: rtl/decode_pipe_stage_if.sv
// FETCH/EXECUTE handshake and registered decode bundle of the DECODE stage.
// master = surrounding pipeline, slave = decode_pipe_stage.
interface decode_pipe_stage_if #(
    parameter int ADDR_SIZE  = 32,
    parameter int INSTR_SIZE = 32,
    parameter int REG_ADDR   = 5,
    parameter int REG_SIZE   = 32
);

    logic                  in_valid;
    logic                  in_ready;
    logic [ADDR_SIZE-1:0]  pc;
    logic [INSTR_SIZE-1:0] instruction;
    logic                  flush;

    logic                  out_valid;
    logic                  out_ready;
    logic [ADDR_SIZE-1:0]  out_pc;
    logic [ADDR_SIZE-1:0]  mimmediat;
    logic [REG_SIZE-1:0]   rout_reg1;
    logic [REG_SIZE-1:0]   rout_reg2;
    logic [REG_ADDR-1:0]   out_addr_reg1;
    logic [REG_ADDR-1:0]   out_addr_reg2;
    logic [REG_ADDR-1:0]   dest_reg;
    logic [5:0]            op_code;
    logic [5:0]            funct_code;
    logic                  regwrite;
    logic                  memtoreg;
    logic                  branch;
    logic                  memwrite;
    logic                  memread;
    logic                  byteword;
    logic                  alusrc;
    logic                  is_mult;

    modport master (
        output in_valid, pc, instruction, flush, out_ready,
        input  in_ready, out_valid, out_pc, mimmediat,
        input  rout_reg1, rout_reg2,
        input  out_addr_reg1, out_addr_reg2, dest_reg,
        input  op_code, funct_code,
        input  regwrite, memtoreg, branch, memwrite,
        input  memread, byteword, alusrc, is_mult
    );

    modport slave (
        input  in_valid, pc, instruction, flush, out_ready,
        output in_ready, out_valid, out_pc, mimmediat,
        output rout_reg1, rout_reg2,
        output out_addr_reg1, out_addr_reg2, dest_reg,
        output op_code, funct_code,
        output regwrite, memtoreg, branch, memwrite,
        output memread, byteword, alusrc, is_mult
    );

endinterface

// File: rtl/decode_pipe_stage_ctrl.sv
// decode_ctrl: combinational opcode -> control-bit mapping for DECODE.
// Unknown opcodes decode to all-zero controls (a harmless no-op).
module decode_ctrl
    import decode_pipe_stage_pkg::*;
(
    input  logic [5:0] op_code,
    output ctrl_t      ctrl
);

    always_comb begin
        ctrl = '0;
        unique case (1'b1)
            op_code == OP_RTYPE: begin
                ctrl.regwrite = 1'b1;
            end
            op_code == OP_ADDI: begin
                ctrl.regwrite = 1'b1;
                ctrl.alusrc   = 1'b1;
            end
            op_code == OP_LDW,
            op_code == OP_LDB: begin
                ctrl.regwrite = 1'b1;
                ctrl.memtoreg = 1'b1;
                ctrl.memread  = 1'b1;
                ctrl.alusrc   = 1'b1;
                ctrl.byteword = (op_code == OP_LDB);
            end
            op_code == OP_STW,
            op_code == OP_STB: begin
                ctrl.memwrite = 1'b1;
                ctrl.alusrc   = 1'b1;
                ctrl.byteword = (op_code == OP_STB);
            end
            op_code == OP_BEQ: begin
                ctrl.branch = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/decode_pipe_stage.sv
// DECODE stage: ID/EX register with load-use and multiply interlocks.
// Define DECODE_MULT_SB_EN to build the multiply-result scoreboard.
module decode_pipe_stage
    import decode_pipe_stage_pkg::*;
#(
    parameter int ADDR_SIZE  = 32,
    parameter int INSTR_SIZE = 32,
    parameter int REG_ADDR   = 5,
    parameter int REG_SIZE   = 32,
    parameter int MULT_LAT   = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    decode_pipe_stage_if.slave   bus,
    output logic [REG_ADDR-1:0]  src_reg1,
    output logic [REG_ADDR-1:0]  src_reg2,
    input  logic [REG_SIZE-1:0]  rin_reg1,
    input  logic [REG_SIZE-1:0]  rin_reg2,
    output logic [ADDR_SIZE-1:0] jump_addr,
    output logic                 is_jump,
    output logic                 hazard
);

    if (INSTR_SIZE < 32 || MULT_LAT < 1 || MULT_LAT > 15) begin : g_bad_cfg
        $error("decode_pipe_stage: unsupported parameters");
    end

    localparam logic [ADDR_SIZE-1:0] JMASK =
        {4'hF, {(ADDR_SIZE-4){1'b0}}};

    logic [31:0]          ins;
    logic [5:0]           in_op;
    logic [5:0]           in_fn;
    logic [REG_ADDR-1:0]  in_rd;
    logic [REG_ADDR-1:0]  in_dst;
    logic [ADDR_SIZE-1:0] in_imm;
    ctrl_t                in_ctrl;
    logic                 in_rdy;
    logic                 accept;
    logic                 lu_hit;
    logic                 mul_hit;

    logic                 v_q;
    logic [ADDR_SIZE-1:0] pc_q;
    logic [ADDR_SIZE-1:0] imm_q;
    logic [REG_SIZE-1:0]  r1_q;
    logic [REG_SIZE-1:0]  r2_q;
    logic [REG_ADDR-1:0]  a1_q;
    logic [REG_ADDR-1:0]  a2_q;
    logic [REG_ADDR-1:0]  dst_q;
    id_ex_ctl_t           ctl_q;

    assign ins      = bus.instruction[31:0];
    assign in_op    = ins[OPC_HI:OPC_LO];
    assign in_fn    = ins[FN_HI:FN_LO];
    assign src_reg1 = REG_ADDR'(ins[RS_HI:RS_LO]);
    assign src_reg2 = REG_ADDR'(ins[RT_HI:RT_LO]);
    assign in_rd    = REG_ADDR'(ins[RD_HI:RD_LO]);
    assign in_dst   = (in_op == OP_RTYPE) ? in_rd : src_reg2;
    assign in_imm   = ADDR_SIZE'($signed(ins[IMM_HI:0]));

    decode_ctrl u_ctrl (
        .op_code (in_op),
        .ctrl    (in_ctrl)
    );

    assign jump_addr = (bus.pc & JMASK)
                     | ADDR_SIZE'({ins[JT_HI:0], 2'b00});
    assign is_jump   = bus.in_valid && (in_op == OP_JUMP)
                     && !bus.flush;

    // A load in EXECUTE cannot forward to the very next instruction.
    assign lu_hit = v_q && ctl_q.ctrl.memread
                 && (dst_q != '0)
                 && ((dst_q == src_reg1) || (dst_q == src_reg2));

`ifdef DECODE_MULT_SB_EN
    logic [3:0]          mult_cnt;
    logic [REG_ADDR-1:0] mult_dst;

    // Only the most recently transferred multiply is tracked.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mult_cnt <= '0;
            mult_dst <= '0;
        end else if (v_q && bus.out_ready && ctl_q.is_mult) begin
            mult_cnt <= 4'(MULT_LAT);
            mult_dst <= dst_q;
        end else if (mult_cnt != '0) begin
            mult_cnt <= mult_cnt - 4'd1;
        end
    end

    assign mul_hit = (mult_cnt != '0) && (mult_dst != '0)
                  && ((mult_dst == src_reg1)
                   || (mult_dst == src_reg2));
`else
    assign mul_hit = 1'b0;
`endif

    assign hazard = lu_hit || mul_hit;
    assign in_rdy = !bus.flush && !hazard
                 && (!v_q || bus.out_ready);
    assign accept = bus.in_valid && in_rdy;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            v_q   <= 1'b0;
            pc_q  <= '0;
            imm_q <= '0;
            r1_q  <= '0;
            r2_q  <= '0;
            a1_q  <= '0;
            a2_q  <= '0;
            dst_q <= '0;
            ctl_q <= '0;
        end else if (bus.flush) begin
            v_q <= 1'b0;
        end else if (accept) begin
            v_q           <= 1'b1;
            pc_q          <= bus.pc;
            imm_q         <= in_imm;
            r1_q          <= rin_reg1;
            r2_q          <= rin_reg2;
            a1_q          <= src_reg1;
            a2_q          <= src_reg2;
            dst_q         <= in_dst;
            ctl_q.op      <= in_op;
            ctl_q.fn      <= in_fn;
            ctl_q.ctrl    <= in_ctrl;
            ctl_q.is_mult <= is_mul_op(in_op, in_fn);
        end else if (bus.out_ready) begin
            v_q <= 1'b0;
        end
    end

    assign bus.in_ready      = in_rdy;
    assign bus.out_valid     = v_q;
    assign bus.out_pc        = pc_q;
    assign bus.mimmediat     = imm_q;
    assign bus.rout_reg1     = r1_q;
    assign bus.rout_reg2     = r2_q;
    assign bus.out_addr_reg1 = a1_q;
    assign bus.out_addr_reg2 = a2_q;
    assign bus.dest_reg      = dst_q;
    assign bus.op_code       = ctl_q.op;
    assign bus.funct_code    = ctl_q.fn;
    assign bus.regwrite      = ctl_q.ctrl.regwrite;
    assign bus.memtoreg      = ctl_q.ctrl.memtoreg;
    assign bus.branch        = ctl_q.ctrl.branch;
    assign bus.memwrite      = ctl_q.ctrl.memwrite;
    assign bus.memread       = ctl_q.ctrl.memread;
    assign bus.byteword      = ctl_q.ctrl.byteword;
    assign bus.alusrc        = ctl_q.ctrl.alusrc;
    assign bus.is_mult       = ctl_q.is_mult;

endmodule

// File: tb/tb_decode_pipe_stage.sv
// Directed and randomised bench for decode_pipe_stage with a
// transaction-level reference model of the stage.
module tb_decode_pipe_stage;
    import decode_pipe_stage_pkg::*;

    localparam int LAT = 4;
    localparam int MR  = 2;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    decode_pipe_stage_if #(
        .ADDR_SIZE(32), .INSTR_SIZE(32),
        .REG_ADDR(5), .REG_SIZE(32)
    ) bus ();

    logic [4:0]  src_reg1, src_reg2;
    logic [31:0] rin_reg1, rin_reg2, jump_addr;
    logic        is_jump, hazard;
    logic [31:0] rf [32];

    assign rin_reg1 = rf[src_reg1];
    assign rin_reg2 = rf[src_reg2];

    decode_pipe_stage #(
        .ADDR_SIZE(32), .INSTR_SIZE(32), .REG_ADDR(5),
        .REG_SIZE(32), .MULT_LAT(LAT)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus),
        .src_reg1(src_reg1), .src_reg2(src_reg2),
        .rin_reg1(rin_reg1), .rin_reg2(rin_reg2),
        .jump_addr(jump_addr), .is_jump(is_jump),
        .hazard(hazard)
    );

    int checks = 0;
    int failures = 0;

    // Model of what EXECUTE should see.
    bit          m_v;
    logic [31:0] m_pc, m_imm, m_r1, m_r2;
    logic [4:0]  m_a1, m_a2, m_dst;
    logic [5:0]  m_op, m_fn;
    logic [6:0]  m_ctl;
    logic        m_mul;
    int          edges = 0;
`ifdef DECODE_MULT_SB_EN
    int          mult_t;
    logic [4:0]  mult_dst;
`endif

    logic        obs_hz, obs_rdy, obs_ov;
    logic [4:0]  obs_a1;
    logic [31:0] obs_pc;

    task automatic chk(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // {regwrite,memtoreg,branch,memwrite,memread,byteword,alusrc}
    function automatic logic [6:0] ref_ctrl(input logic [5:0] op);
        if (op == OP_RTYPE) return 7'b1000000;
        if (op == OP_ADDI)  return 7'b1000001;
        if (op == OP_LDW)   return 7'b1100101;
        if (op == OP_LDB)   return 7'b1100111;
        if (op == OP_STW)   return 7'b0001001;
        if (op == OP_STB)   return 7'b0001011;
        if (op == OP_BEQ)   return 7'b0010000;
        return 7'b0;
    endfunction

    function automatic logic [31:0] mk_r(input logic [4:0] rs,
        input logic [4:0] rt, input logic [4:0] rd,
        input logic [5:0] fn);
        return {OP_RTYPE, rs, rt, rd, 5'd0, fn};
    endfunction

    function automatic logic [31:0] mk_i(input logic [5:0] op,
        input logic [4:0] rs, input logic [4:0] rt,
        input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] i;
        logic [5:0]  op;
        logic [5:0]  fn;
        i = $urandom;
        case ($urandom_range(0, 9))
            0, 1, 2: op = OP_RTYPE;
            3:       op = OP_LDW;
            4:       op = OP_LDB;
            5:       op = OP_STW;
            6:       op = OP_STB;
            7:       op = OP_ADDI;
            8:       op = OP_BEQ;
            default: op = OP_JUMP;
        endcase
        case ($urandom_range(0, 2))
            0:       fn = FN_ADD;
            1:       fn = FN_SUB;
            default: fn = FN_MUL;
        endcase
        i[31:26] = op;
        if (op != OP_JUMP) begin
            i[25:21] = 5'($urandom_range(0, 7));
            i[20:16] = 5'($urandom_range(0, 7));
        end
        if (op == OP_RTYPE) begin
            i[15:11] = 5'($urandom_range(0, 7));
            i[5:0]   = fn;
        end
        return i;
    endfunction

    task automatic model_zero();
        m_v = 0; m_pc = 0; m_imm = 0; m_r1 = 0; m_r2 = 0;
        m_a1 = 0; m_a2 = 0; m_dst = 0; m_op = 0; m_fn = 0;
        m_ctl = 0; m_mul = 0;
`ifdef DECODE_MULT_SB_EN
        mult_t = -1000;
        mult_dst = 0;
`endif
    endtask

    task automatic drive(input logic v, input logic [31:0] pc,
        input logic [31:0] ins, input logic fl, input logic ordy);
        bus.in_valid    = v;
        bus.pc          = pc;
        bus.instruction = ins;
        bus.flush       = fl;
        bus.out_ready   = ordy;
    endtask

    // One cycle: compare at negedge+1, advance model on posedge.
    task automatic tick();
        logic [31:0] i;
        logic [4:0]  rs, rt;
        logic [5:0]  op;
        logic        hz, rdy;
        #1;
        if (!reset) model_zero();
        i  = bus.instruction;
        op = i[31:26];
        rs = i[25:21];
        rt = i[20:16];
        hz = m_v && m_ctl[MR] && (m_dst != 0)
          && (m_dst == rs || m_dst == rt);
`ifdef DECODE_MULT_SB_EN
        if ((edges - mult_t <= LAT) && (mult_dst != 0)
            && (mult_dst == rs || mult_dst == rt)) hz = 1'b1;
`endif
        rdy = !bus.flush && !hz && (!m_v || bus.out_ready);
        chk("hazard", hazard, hz);
        chk("in_ready", bus.in_ready, rdy);
        chk("src_reg1", src_reg1, rs);
        chk("src_reg2", src_reg2, rt);
        chk("is_jump", is_jump,
            bus.in_valid && op == OP_JUMP && !bus.flush);
        chk("jump_addr", jump_addr,
            {bus.pc[31:28], i[25:0], 2'b00});
        chk("out_valid", bus.out_valid, m_v);
        chk("out_pc", bus.out_pc, m_pc);
        chk("mimmediat", bus.mimmediat, m_imm);
        chk("rout_reg1", bus.rout_reg1, m_r1);
        chk("rout_reg2", bus.rout_reg2, m_r2);
        chk("fields", {bus.out_addr_reg1, bus.out_addr_reg2,
            bus.dest_reg, bus.op_code, bus.funct_code,
            bus.regwrite, bus.memtoreg, bus.branch, bus.memwrite,
            bus.memread, bus.byteword, bus.alusrc, bus.is_mult},
            {m_a1, m_a2, m_dst, m_op, m_fn, m_ctl, m_mul});
        obs_hz  = hazard;
        obs_rdy = bus.in_ready;
        obs_ov  = bus.out_valid;
        obs_a1  = bus.out_addr_reg1;
        obs_pc  = bus.out_pc;
        @(posedge clk);
        if (!reset) begin
            model_zero();
        end else begin
`ifdef DECODE_MULT_SB_EN
            if (m_v && bus.out_ready && m_mul) begin
                mult_t   = edges;
                mult_dst = m_dst;
            end
`endif
            if (bus.flush) begin
                m_v = 0;
            end else if (bus.in_valid && rdy) begin
                m_v   = 1;
                m_pc  = bus.pc;
                m_imm = {{11{i[20]}}, i[20:0]};
                m_r1  = rf[rs];
                m_r2  = rf[rt];
                m_a1  = rs;
                m_a2  = rt;
                m_op  = op;
                m_fn  = i[5:0];
                m_dst = (op == OP_RTYPE) ? i[15:11] : rt;
                m_ctl = ref_ctrl(op);
                m_mul = (op == OP_RTYPE) && (i[5:0] == FN_MUL);
            end else if (bus.out_ready) begin
                m_v = 0;
            end
        end
        edges++;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, hz_n, acc_n, mul_exp;
`ifdef DECODE_MULT_SB_EN
        mul_exp = LAT + 1;
`else
        mul_exp = 1;
`endif
        for (int k = 0; k < 32; k++) rf[k] = $urandom;
        model_zero();
        reset = 1'b0;
        drive(0, 0, 0, 0, 1);
        @(negedge clk);
        tick();
        chk("rst_out_valid", obs_ov, 0);
        chk("rst_out_pc", obs_pc, 0);
        reset = 1'b1;

        for (int k = 0; k < 6; k++) begin
            drive(1, 32'h100 + 4 * k,
                  mk_r(1, 2, 5'(8 + k), FN_ADD), 0, 1);
            tick();
            chk("stream_ready", obs_rdy, 1);
        end

        drive(1, 32'h200, mk_i(OP_LDW, 1, 3, 16'h8), 0, 1);
        tick();
        drive(1, 32'h204, mk_r(3, 5, 4, FN_ADD), 0, 1);
        n = 0; hz_n = 0;
        do begin
            tick(); n++; hz_n += int'(obs_hz);
        end while (!obs_rdy && n < 10);
        chk("lu_cycles", n, 2);
        chk("lu_hazard", hz_n, 1);
        chk("lu_bubble", obs_ov, 0);
        drive(0, 0, 0, 0, 1);
        tick();
        chk("lu_addr1", obs_a1, 3);
        chk("lu_issue", obs_ov, 1);

        drive(1, 32'h300, mk_r(1, 2, 6, FN_MUL), 0, 1);
        tick();
        drive(0, 0, 0, 0, 1);
        tick();
        drive(1, 32'h304, mk_r(6, 1, 7, FN_ADD), 0, 1);
        n = 0;
        do begin
            tick(); n++;
        end while (!obs_rdy && n < 20);
        chk("mul_wait", n, mul_exp);

        drive(1, 32'h308, mk_r(1, 2, 6, FN_MUL), 0, 1);
        tick();
        drive(0, 0, 0, 0, 1);
        tick();
        drive(1, 32'h30c, mk_r(2, 3, 9, FN_SUB), 0, 1);
        tick();
        chk("mul_indep", obs_rdy, 1);

        drive(1, 32'h400, mk_r(1, 2, 10, FN_ADD), 0, 1);
        tick();
        acc_n = 0;
        for (int k = 0; k < 3; k++) begin
            drive(1, 32'h404, mk_r(1, 2, 11, FN_ADD), 0, 0);
            tick();
            acc_n += int'(obs_rdy);
            chk("stall_pc", obs_pc, 32'h400);
        end
        chk("stall_accepts", acc_n, 0);
        drive(1, 32'h404, mk_r(1, 2, 11, FN_ADD), 0, 1);
        tick();
        chk("stall_release", obs_rdy, 1);
        drive(0, 0, 0, 0, 1);
        tick();
        chk("stall_next_pc", obs_pc, 32'h404);

        drive(1, 32'h1000_0040, {OP_JUMP, 26'h10}, 0, 1);
        #1;
        chk("jump_flag", is_jump, 1);
        chk("jump_target", jump_addr, 32'h1000_0040);
        bus.flush = 1'b1;
        #1;
        chk("jump_flush", is_jump, 0);
        tick();

        drive(1, 32'h500, mk_r(1, 2, 6, FN_MUL), 0, 1);
        tick();
        drive(1, 32'h504, mk_i(OP_LDW, 1, 3, 16'h0), 0, 1);
        tick();
        drive(1, 32'h508, mk_r(3, 6, 4, FN_ADD), 0, 0);
        tick();
        chk("rst_pre_hazard", obs_hz, 1);
        reset = 1'b0;
        tick();
        chk("rst_mid_valid", obs_ov, 0);
        chk("rst_mid_pc", obs_pc, 0);
        reset = 1'b1;
        drive(1, 32'h50c, mk_r(3, 6, 4, FN_ADD), 0, 1);
        tick();
        chk("rst_accept", obs_rdy, 1);

        for (int c = 0; c < 1500; c++) begin
            reset = ($urandom_range(0, 199) != 0);
            drive(($urandom_range(0, 3) != 0), $urandom,
                  rand_instr(), ($urandom_range(0, 15) == 0),
                  ($urandom_range(0, 3) != 0));
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d",
                 checks, failures);
        $finish;
    end

endmodule
